npc_array_engine: RTL and testbench

NPC_ARRAY_ENGINE -- requirements
Module: npc_array_engine

---
 rtl/npc_array_engine.sv | 209 ++++++++++++++++++++
 tb/tb_npc_array_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/npc_array_engine.sv
// NPC array engine: per-frame sweep that advances a bank of patrolling enemies.
// Ports: Clk, Reset_n (async low), frame_tick, hit/spawn (per channel),
//        enemy_x/state/life (packed, ch0 in LSBs), busy, all_dead, overrun.
module npc_array_engine #(
    parameter int N_CH        = 4,
    parameter int COORD_W     = 10,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int SPEED       = 2,
    parameter int SPAWN_X     = 320,
    parameter int LIFE_INIT   = 3,
    parameter int HURT_FRAMES = 16
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      frame_tick,
    input  logic [N_CH-1:0]           hit,
    input  logic [N_CH-1:0]           spawn,
    output logic [N_CH*COORD_W-1:0]   enemy_x,
    output logic [N_CH*2-1:0]         enemy_state,
    output logic [N_CH*4-1:0]         enemy_life,
    output logic                      busy,
    output logic                      all_dead,
    output logic                      overrun
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(HURT_FRAMES + 1);
    localparam int XW    = COORD_W + 1;

    localparam logic [XW-1:0]      SPD_E  = XW'(SPEED);
    localparam logic [XW-1:0]      XMIN_E = XW'(X_MIN);
    localparam logic [XW-1:0]      XMAX_E = XW'(X_MAX);
    localparam logic [IDX_W-1:0]   LAST   = IDX_W'(N_CH - 1);

    localparam logic [1:0] ST_DEAD = 2'd0;
    localparam logic [1:0] ST_PR   = 2'd1;
    localparam logic [1:0] ST_PL   = 2'd2;
    localparam logic [1:0] ST_HURT = 2'd3;

    typedef enum logic {IDLE, SWEEP} ctl_t;

    ctl_t             ctl, ctl_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic             upd;

    logic [COORD_W-1:0] x_q    [N_CH];
    logic [1:0]         st_q   [N_CH];
    logic [3:0]         life_q [N_CH];
    logic [CNT_W-1:0]   cnt_q  [N_CH];
    logic [N_CH-1:0]    dir_q;
    logic [N_CH-1:0]    hit_p;
    logic [N_CH-1:0]    spawn_p;
    logic [N_CH-1:0]    clr;

    logic [COORD_W-1:0] cur_x, nx_x;
    logic [1:0]         cur_st, nx_st;
    logic [3:0]         cur_life, nx_life;
    logic [CNT_W-1:0]   cur_cnt, nx_cnt;
    logic               cur_dir, nx_dir;
    logic               cur_hit, cur_spawn;
    logic [XW-1:0]      xe;

    // Sweep controller
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ctl     <= IDLE;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            ctl <= ctl_nx;
            idx <= idx_nx;
            if (frame_tick && ctl == SWEEP)
                overrun <= 1'b1;
        end
    end

    always_comb begin
        ctl_nx = ctl;
        idx_nx = idx;
        upd    = 1'b0;
        case (ctl)
            IDLE: begin
                if (frame_tick) begin
                    ctl_nx = SWEEP;
                    idx_nx = '0;
                end
            end
            SWEEP: begin
                upd = 1'b1;
                if (idx == LAST) ctl_nx = IDLE;
                else             idx_nx = idx + 1'b1;
            end
            default: ctl_nx = IDLE;
        endcase
    end

    assign busy = (ctl == SWEEP);

    // Pending bits: a fresh pulse beats the clear of the channel being updated
    always_comb begin
        clr = '0;
        if (upd) clr[idx] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_p   <= '0;
            spawn_p <= '0;
        end else begin
            hit_p   <= hit   | (hit_p   & ~clr);
            spawn_p <= spawn | (spawn_p & ~clr);
        end
    end

    // Next-state for the channel currently selected by the sweep
    assign cur_x     = x_q[idx];
    assign cur_st    = st_q[idx];
    assign cur_life  = life_q[idx];
    assign cur_cnt   = cnt_q[idx];
    assign cur_dir   = dir_q[idx];
    assign cur_hit   = hit_p[idx];
    assign cur_spawn = spawn_p[idx];
    assign xe        = {1'b0, cur_x};

    always_comb begin
        nx_x    = cur_x;
        nx_st   = cur_st;
        nx_life = cur_life;
        nx_cnt  = cur_cnt;
        nx_dir  = cur_dir;
        case (cur_st)
            ST_DEAD: begin
                if (cur_spawn) begin
                    nx_x    = COORD_W'(SPAWN_X);
                    nx_life = 4'(LIFE_INIT);
                    nx_st   = ST_PR;
                end
            end
            ST_PR, ST_PL: begin
                if (cur_hit) begin
                    if (cur_life == 4'd1) begin
                        nx_st   = ST_DEAD;
                        nx_life = 4'd0;
                    end else begin
                        nx_st   = ST_HURT;
                        nx_life = cur_life - 4'd1;
                        nx_cnt  = CNT_W'(HURT_FRAMES);
                        nx_dir  = (cur_st == ST_PL);
                    end
                end else if (cur_st == ST_PR) begin
                    if (xe + SPD_E >= XMAX_E) begin
                        nx_x  = COORD_W'(X_MAX);
                        nx_st = ST_PL;
                    end else begin
                        nx_x = cur_x + COORD_W'(SPEED);
                    end
                end else begin
                    if (xe <= XMIN_E + SPD_E) begin
                        nx_x  = COORD_W'(X_MIN);
                        nx_st = ST_PR;
                    end else begin
                        nx_x = cur_x - COORD_W'(SPEED);
                    end
                end
            end
            default: begin
                // HURT: frozen and invulnerable until the counter expires
                if (cur_cnt <= CNT_W'(1)) begin
                    nx_cnt = '0;
                    nx_st  = cur_dir ? ST_PL : ST_PR;
                end else begin
                    nx_cnt = cur_cnt - CNT_W'(1);
                end
            end
        endcase
    end

    // Channel state bank
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                x_q[i]    <= '0;
                st_q[i]   <= ST_DEAD;
                life_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            dir_q <= '0;
        end else if (upd) begin
            x_q[idx]    <= nx_x;
            st_q[idx]   <= nx_st;
            life_q[idx] <= nx_life;
            cnt_q[idx]  <= nx_cnt;
            dir_q[idx]  <= nx_dir;
        end
    end

    logic [N_CH-1:0] dead;

    for (genvar g = 0; g < N_CH; g++) begin : g_pack
        assign enemy_x[g*COORD_W +: COORD_W] = x_q[g];
        assign enemy_state[g*2 +: 2]         = st_q[g];
        assign enemy_life[g*4 +: 4]          = life_q[g];
        assign dead[g]                       = (st_q[g] == ST_DEAD);
    end

    assign all_dead = &dead;

endmodule

// File: tb/tb_npc_array_engine.sv
// Directed bench for npc_array_engine: spawn/patrol, hurt, death,
// sweep timing, overrun, pending race and mid-sweep reset.
module tb_npc_array_engine;

    localparam int N  = 4;
    localparam int CW = 10;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          frame_tick = 1'b0;
    logic [N-1:0]  hit = '0;
    logic [N-1:0]  spawn = '0;
    logic [N*CW-1:0] enemy_x;
    logic [N*2-1:0]  enemy_state;
    logic [N*4-1:0]  enemy_life;
    logic          busy;
    logic          all_dead;
    logic          overrun;

    int nvec = 0;
    int nerr = 0;

    npc_array_engine #(
        .N_CH(N), .COORD_W(CW), .X_MIN(0), .X_MAX(20), .SPEED(2),
        .SPAWN_X(10), .LIFE_INIT(3), .HURT_FRAMES(2)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .hit(hit), .spawn(spawn),
        .enemy_x(enemy_x), .enemy_state(enemy_state),
        .enemy_life(enemy_life), .busy(busy),
        .all_dead(all_dead), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_ch(input string tag, input int c, input int x,
                          input int st, input int life);
        check({tag, "_x"},    64'(enemy_x[c*CW +: CW]), 64'(x));
        check({tag, "_st"},   64'(enemy_state[c*2 +: 2]), 64'(st));
        check({tag, "_life"}, 64'(enemy_life[c*4 +: 4]), 64'(life));
    endtask

    task automatic pulse(input logic [N-1:0] h, input logic [N-1:0] s);
        @(negedge Clk);
        hit = h;
        spawn = s;
        @(negedge Clk);
        hit = '0;
        spawn = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check(tag, 64'(busy), 64'(0));
    endtask

    task automatic frame();
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        wait_idle("sweep_end");
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_ovr"},   64'(overrun), 64'(0));
        check({tag, "_alld"},  64'(all_dead), 64'(1));
        check({tag, "_x"},     64'(enemy_x), 64'(0));
        check({tag, "_st"},    64'(enemy_state), 64'(0));
        check({tag, "_life"},  64'(enemy_life), 64'(0));
    endtask

    initial begin
        int bc;

        repeat (2) @(negedge Clk);
        chk_reset("rst");
        Reset_n = 1'b1;

        // Spawn and patrol, both bounds
        pulse(4'b0000, 4'b0001);
        frame();
        chk_ch("spawn", 0, 10, 1, 3);
        check("spawn_ch1", 64'(enemy_state[3:2]), 64'(0));
        check("spawn_alld", 64'(all_dead), 64'(0));
        repeat (4) frame();
        chk_ch("pr18", 0, 18, 1, 3);
        frame();
        chk_ch("rbound", 0, 20, 2, 3);
        frame();
        chk_ch("pl18", 0, 18, 2, 3);
        repeat (8) frame();
        chk_ch("pl2", 0, 2, 2, 3);
        frame();
        chk_ch("lbound", 0, 0, 1, 3);
        frame();
        chk_ch("pr2", 0, 2, 1, 3);

        // Hurt cycle
        do_reset();
        pulse(4'b0000, 4'b0001);
        frame();
        frame();
        chk_ch("pre_hit", 0, 12, 1, 3);
        pulse(4'b0001, 4'b0000);
        frame();
        chk_ch("hit1", 0, 12, 3, 2);
        pulse(4'b0001, 4'b0000);
        frame();
        chk_ch("hurt_ign", 0, 12, 3, 2);
        frame();
        chk_ch("hurt_end", 0, 12, 1, 2);
        frame();
        chk_ch("resume", 0, 14, 1, 2);

        // Death
        pulse(4'b0001, 4'b0000);
        frame();
        chk_ch("hit2", 0, 14, 3, 1);
        frame();
        frame();
        chk_ch("hurt_end2", 0, 14, 1, 1);
        check("alive_alld", 64'(all_dead), 64'(0));
        pulse(4'b0001, 4'b0000);
        frame();
        chk_ch("death", 0, 14, 0, 0);
        check("death_alld", 64'(all_dead), 64'(1));

        // Busy width and overrun
        check("ovr_pre", 64'(overrun), 64'(0));
        bc = 0;
        @(negedge Clk);
        frame_tick = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            if (busy) bc++;
            frame_tick = (k == 0);
        end
        check("busy_cycles", 64'(bc), 64'(4));
        check("ovr_set", 64'(overrun), 64'(1));
        frame();
        check("ovr_sticky", 64'(overrun), 64'(1));

        // Hit arriving in the cycle ch2 is updated is deferred
        do_reset();
        check("ovr_clr", 64'(overrun), 64'(0));
        pulse(4'b0000, 4'b0100);
        frame();
        chk_ch("ch2_spawn", 2, 10, 1, 3);
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        hit = 4'b0100;
        @(negedge Clk);
        hit = '0;
        wait_idle("race_end");
        chk_ch("race_defer", 2, 12, 1, 3);
        frame();
        chk_ch("race_apply", 2, 12, 3, 2);

        // Spawn on a live channel is dropped
        pulse(4'b0000, 4'b0100);
        frame();
        chk_ch("spawn_drop", 2, 12, 3, 2);

        // Reset mid-sweep, then a full sweep from channel 0
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        check("mid_busy", 64'(busy), 64'(1));
        Reset_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge Clk);
        Reset_n = 1'b1;
        pulse(4'b0000, 4'b1111);
        frame();
        check("all_x", 64'(enemy_x), 64'({4{10'd10}}));
        check("all_life", 64'(enemy_life), 64'(16'h3333));
        check("all_st", 64'(enemy_state), 64'(8'h55));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
